// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared downstream memory port.
// The arbiter takes the slave view; the requesters and memory model take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  // Requester side, index 0 = instruction fetch, index 1 = MEM stage
  logic [1:0]                 rq_rd;
  logic [1:0]                 rq_wr;
  logic [1:0][ADDR_WIDTH-1:0] rq_addr;
  logic [1:0][DATA_WIDTH-1:0] rq_wr_data;
  logic [1:0][BE_WIDTH-1:0]   rq_wr_be;
  logic [DATA_WIDTH-1:0]      rq_data;
  logic [1:0]                 rq_waitrequest;

  // Downstream memory side
  logic                       mem_rd;
  logic                       mem_wr;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wr_data;
  logic [BE_WIDTH-1:0]        mem_wr_be;
  logic [DATA_WIDTH-1:0]      mem_data;
  logic                       mem_waitrequest;

  modport slave (
    input  rq_rd, rq_wr, rq_addr, rq_wr_data, rq_wr_be,
    output rq_data, rq_waitrequest,
    output mem_rd, mem_wr, mem_addr, mem_wr_data, mem_wr_be,
    input  mem_data, mem_waitrequest
  );

  modport master (
    output rq_rd, rq_wr, rq_addr, rq_wr_data, rq_wr_be,
    input  rq_data, rq_waitrequest,
    input  mem_rd, mem_wr, mem_addr, mem_wr_data, mem_wr_be,
    output mem_data, mem_waitrequest
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single cache/memory port (ifetch = port 0, MEM = port 1).
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise port 1 has fixed priority.

module mem_port_arbiter_chk #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input logic                  clock,
  input logic                  reset_n,
  input logic [1:0]            rq_rd,
  input logic [1:0]            rq_wr,
  input logic                  busy,
  input logic                  owner,
  input logic                  last_owner,
  input logic                  mem_rd,
  input logic                  mem_wr,
  input logic [ADDR_WIDTH-1:0] mem_addr,
  input logic [DATA_WIDTH-1:0] mem_wr_data,
  input logic [BE_WIDTH-1:0]   mem_wr_be,
  input logic                  mem_waitrequest
);
  // A port raising rd and wr together is served as a write, but it is a requester bug.
  a_rd_wr_port0: assert property (@(posedge clock) disable iff (!reset_n)
    !(rq_rd[0] && rq_wr[0]));
  a_rd_wr_port1: assert property (@(posedge clock) disable iff (!reset_n)
    !(rq_rd[1] && rq_wr[1]));

  a_cmd_exclusive: assert property (@(posedge clock) disable iff (!reset_n)
    !(mem_rd && mem_wr));

  a_idle_quiet: assert property (@(posedge clock) disable iff (!reset_n)
    !busy |-> !(mem_rd || mem_wr));

  a_cmd_held: assert property (@(posedge clock) disable iff (!reset_n)
    (busy && mem_waitrequest) |=> ($stable(mem_rd) && $stable(mem_wr) &&
      $stable(mem_addr) && $stable(mem_wr_data) && $stable(mem_wr_be)));

  a_last_owner: assert property (@(posedge clock) disable iff (!reset_n)
    (busy && !mem_waitrequest) |=> (last_owner == $past(owner)));
endmodule

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input logic            clock,
  input logic            reset_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic                  cmd_rd_q, cmd_rd_d;
  logic                  cmd_wr_q, cmd_wr_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wr_data_q, cmd_wr_data_d;
  logic [BE_WIDTH-1:0]   cmd_wr_be_q, cmd_wr_be_d;

  logic [1:0]            req_s;
  logic                  grant_s;
  logic                  complete_s;

  assign req_s      = bus.rq_rd | bus.rq_wr;
  assign complete_s = (state_q == BUSY) && !bus.mem_waitrequest;

  // Winner selection among the ports requesting in IDLE
  always_comb begin
    grant_s = 1'b0;
    if (req_s == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_s = ~last_owner_q;
`else
      grant_s = 1'b1;
`endif
    end else begin
      grant_s = req_s[1];
    end
  end

  // Next-state logic; the command register is cleared on completion so mem_rd/mem_wr are 0 in IDLE
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    cmd_rd_d      = cmd_rd_q;
    cmd_wr_d      = cmd_wr_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_wr_data_d = cmd_wr_data_q;
    cmd_wr_be_d   = cmd_wr_be_q;
    case (state_q)
      IDLE: begin
        if (req_s != 2'b00) begin
          state_d       = BUSY;
          owner_d       = grant_s;
          cmd_wr_d      = bus.rq_wr[grant_s];
          cmd_rd_d      = bus.rq_rd[grant_s] & ~bus.rq_wr[grant_s];
          cmd_addr_d    = bus.rq_addr[grant_s];
          cmd_wr_data_d = bus.rq_wr_data[grant_s];
          cmd_wr_be_d   = bus.rq_wr_be[grant_s];
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!bus.mem_waitrequest) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          cmd_rd_d     = 1'b0;
          cmd_wr_d     = 1'b0;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d  = IDLE;
        cmd_rd_d = 1'b0;
        cmd_wr_d = 1'b0;
      end
    endcase
  end

  // State, ownership and command registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
      cmd_rd_q      <= 1'b0;
      cmd_wr_q      <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wr_data_q <= '0;
      cmd_wr_be_q   <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      cmd_rd_q      <= cmd_rd_d;
      cmd_wr_q      <= cmd_wr_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wr_data_q <= cmd_wr_data_d;
      cmd_wr_be_q   <= cmd_wr_be_d;
    end
  end

  assign bus.mem_rd      = cmd_rd_q;
  assign bus.mem_wr      = cmd_wr_q;
  assign bus.mem_addr    = cmd_addr_q;
  assign bus.mem_wr_data = cmd_wr_data_q;
  assign bus.mem_wr_be   = cmd_wr_be_q;

  // Stall every requester except the owner on its completion cycle; a dropped request never stalls
  always_comb begin
    bus.rq_waitrequest = req_s;
    bus.rq_data        = '0;
    if (complete_s) begin
      bus.rq_waitrequest[owner_q] = 1'b0;
      bus.rq_data                 = bus.mem_data;
    end else begin
      bus.rq_waitrequest = req_s;
    end
  end

  mem_port_arbiter_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH)
  ) u_chk (
    .clock           (clock),
    .reset_n         (reset_n),
    .rq_rd           (bus.rq_rd),
    .rq_wr           (bus.rq_wr),
    .busy            (state_q == BUSY),
    .owner           (owner_q),
    .last_owner      (last_owner_q),
    .mem_rd          (cmd_rd_q),
    .mem_wr          (cmd_wr_q),
    .mem_addr        (cmd_addr_q),
    .mem_wr_data     (cmd_wr_data_q),
    .mem_wr_be       (cmd_wr_be_q),
    .mem_waitrequest (bus.mem_waitrequest)
  );
endmodule
